// File: rtl/cache_line_controller.sv
// -----------------------------------------------------------------------------
// cache_line_controller
//
// Sequencing FSM for the two-way set-associative LC-3b cache. It sits between
// the CPU memory port and physical memory, beside the cache datapath arrays.
// It detects hit/miss, updates LRU, orders a dirty-victim writeback ahead of the
// line fill, and drives the address-mux and victim-way selects consumed by the
// line address generator.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   mem_read, mem_write   CPU request (both high is treated as a write)
//   hit0, hit1            per-way valid & tag match for the current set
//   lru                   LRU bit of the current set (0 = way0 is victim)
//   valid_victim,
//   dirty_victim          status bits of the way selected by victim_way
//   pmem_resp             physical memory transfer done (one-cycle pulse)
//   mem_resp              CPU request complete (same cycle on a hit)
//   pmem_read, pmem_write physical line read / write requests
//   pmem_address_sel      0 = CPU address, 1 = victim line address
//   victim_way            way chosen for writeback / allocate
//   load_data, data_sel   per-way data write enable, 0 = CPU merge, 1 = pmem line
//   load_tag              per-way tag/valid write enable
//   set_dirty, clear_dirty per-way dirty bit set / clear
//   load_lru, lru_in      LRU write enable and new LRU value
//   hit_count, miss_count saturating performance counters
// -----------------------------------------------------------------------------
module cache_line_controller #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic                 hit0,
   input  logic                 hit1,
   input  logic                 lru,
   input  logic                 valid_victim,
   input  logic                 dirty_victim,
   input  logic                 pmem_resp,
   output logic                 mem_resp,
   output logic                 pmem_read,
   output logic                 pmem_write,
   output logic                 pmem_address_sel,
   output logic                 victim_way,
   output logic [1:0]           load_data,
   output logic                 data_sel,
   output logic [1:0]           load_tag,
   output logic [1:0]           set_dirty,
   output logic [1:0]           clear_dirty,
   output logic                 load_lru,
   output logic                 lru_in,
   output logic [CNT_WIDTH-1:0] hit_count,
   output logic [CNT_WIDTH-1:0] miss_count
);

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      ALLOCATE
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t state;
   logic   victim_q;
   logic   request;
   logic   hit;
   logic   hit_way;

   assign request = mem_read | mem_write;
   assign hit     = hit0 | hit1;
   // Way0 takes priority when both ways report a match.
   assign hit_way = ~hit0;

   // State, latched victim and performance counters. The victim is captured on
   // miss detection so later LRU updates to the set cannot retarget the fill.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         victim_q   <= 1'b0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (request) begin
                  if (hit) begin
                     if (hit_count != '1) hit_count <= hit_count + CNT_ONE;
                  end else begin
                     victim_q <= lru;
                     if (miss_count != '1) miss_count <= miss_count + CNT_ONE;
                     state <= (valid_victim && dirty_victim) ? WRITEBACK : ALLOCATE;
                  end
               end
            end
            WRITEBACK: begin
               if (pmem_resp) state <= ALLOCATE;
            end
            ALLOCATE: begin
               if (pmem_resp) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Output decode. Hits and the fill-completion writes must happen in the same
   // cycle as their trigger, so these depend on inputs as well as state. In
   // IDLE the victim select follows lru so valid_victim/dirty_victim describe
   // the way a miss would evict. Everything is held at 0 while reset is high.
   always_comb begin
      mem_resp         = 1'b0;
      pmem_read        = 1'b0;
      pmem_write       = 1'b0;
      pmem_address_sel = 1'b0;
      victim_way       = 1'b0;
      load_data        = 2'b00;
      data_sel         = 1'b0;
      load_tag         = 2'b00;
      set_dirty        = 2'b00;
      clear_dirty      = 2'b00;
      load_lru         = 1'b0;
      lru_in           = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               victim_way = lru;
               if (request && hit) begin
                  mem_resp = 1'b1;
                  load_lru = 1'b1;
                  lru_in   = ~hit_way;
                  if (mem_write) begin
                     load_data = hit_way ? 2'b10 : 2'b01;
                     set_dirty = hit_way ? 2'b10 : 2'b01;
                  end
               end
            end
            WRITEBACK: begin
               victim_way       = victim_q;
               pmem_write       = 1'b1;
               pmem_address_sel = 1'b1;
            end
            ALLOCATE: begin
               victim_way = victim_q;
               pmem_read  = 1'b1;
               if (pmem_resp) begin
                  load_data   = victim_q ? 2'b10 : 2'b01;
                  data_sel    = 1'b1;
                  load_tag    = victim_q ? 2'b10 : 2'b01;
                  clear_dirty = victim_q ? 2'b10 : 2'b01;
               end
            end
            default: begin
               victim_way = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_line_controller.sv
// -----------------------------------------------------------------------------
// tb_cache_line_controller
//
// Self-checking bench for cache_line_controller. Each transaction is described
// at the protocol level (hit, or miss with optional writeback then fill) and
// the expected strobe pattern for every cycle is built from those rules.
// Inputs are driven on the falling edge and outputs sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_cache_line_controller;

   localparam int CNT_WIDTH = 16;
   localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

   typedef struct packed {
      logic       mem_resp;
      logic       pmem_read;
      logic       pmem_write;
      logic       pmem_address_sel;
      logic       victim_way;
      logic [1:0] load_data;
      logic       data_sel;
      logic [1:0] load_tag;
      logic [1:0] set_dirty;
      logic [1:0] clear_dirty;
      logic       load_lru;
      logic       lru_in;
   } outs_t;

   logic clk;
   logic reset;
   logic mem_read;
   logic mem_write;
   logic hit0;
   logic hit1;
   logic lru;
   logic valid_victim;
   logic dirty_victim;
   logic pmem_resp;
   logic mem_resp;
   logic pmem_read;
   logic pmem_write;
   logic pmem_address_sel;
   logic victim_way;
   logic [1:0] load_data;
   logic data_sel;
   logic [1:0] load_tag;
   logic [1:0] set_dirty;
   logic [1:0] clear_dirty;
   logic load_lru;
   logic lru_in;
   logic [CNT_WIDTH-1:0] hit_count;
   logic [CNT_WIDTH-1:0] miss_count;

   outs_t obs;
   int    checks;
   int    errors;
   int    exp_hits;
   int    exp_misses;

   cache_line_controller #(.CNT_WIDTH(CNT_WIDTH)) dut (
      .clk              (clk),
      .reset            (reset),
      .mem_read         (mem_read),
      .mem_write        (mem_write),
      .hit0             (hit0),
      .hit1             (hit1),
      .lru              (lru),
      .valid_victim     (valid_victim),
      .dirty_victim     (dirty_victim),
      .pmem_resp        (pmem_resp),
      .mem_resp         (mem_resp),
      .pmem_read        (pmem_read),
      .pmem_write       (pmem_write),
      .pmem_address_sel (pmem_address_sel),
      .victim_way       (victim_way),
      .load_data        (load_data),
      .data_sel         (data_sel),
      .load_tag         (load_tag),
      .set_dirty        (set_dirty),
      .clear_dirty      (clear_dirty),
      .load_lru         (load_lru),
      .lru_in           (lru_in),
      .hit_count        (hit_count),
      .miss_count       (miss_count)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Snapshot of every single-bit/strobe output for whole-vector comparison.
   assign obs = {mem_resp, pmem_read, pmem_write, pmem_address_sel, victim_way,
                 load_data, data_sel, load_tag, set_dirty, clear_dirty,
                 load_lru, lru_in};

   function automatic logic [1:0] onehot(input logic way);
      return way ? 2'b10 : 2'b01;
   endfunction

   function automatic int sat_inc(input int value);
      return (value < CNT_MAX) ? value + 1 : value;
   endfunction

   // Drives every DUT input at once.
   task automatic applyStimulus(input logic rd, input logic wr, input logic h0,
                                input logic h1, input logic l, input logic v,
                                input logic d, input logic pr);
      mem_read     = rd;
      mem_write    = wr;
      hit0         = h0;
      hit1         = h1;
      lru          = l;
      valid_victim = v;
      dirty_victim = d;
      pmem_resp    = pr;
   endtask

   // One hit transaction: response and LRU/data updates must be same-cycle.
   task automatic run_hit(input string name, input logic rd, input logic wr,
                          input logic h0, input logic h1, input logic l);
      outs_t exp;
      logic  way;
      @(negedge clk);
      applyStimulus(rd, wr, h0, h1, l, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'b0);
      #1;
      way = h0 ? 1'b0 : 1'b1;
      exp = '0;
      exp.mem_resp   = 1'b1;
      exp.victim_way = l;
      exp.load_lru   = 1'b1;
      exp.lru_in     = ~way;
      if (wr) begin
         exp.load_data = onehot(way);
         exp.set_dirty = onehot(way);
      end
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s hit outputs: got %h expected %h", name, obs, exp);
      end
      exp_hits = sat_inc(exp_hits);
      @(posedge clk);
      #1;
      checks++;
      if ({hit_count, miss_count} !== {CNT_WIDTH'(exp_hits), CNT_WIDTH'(exp_misses)}) begin
         errors++;
         $display("[TB] FAIL %s counters: got %0d/%0d expected %0d/%0d",
                  name, hit_count, miss_count, exp_hits, exp_misses);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, l, 1'b0, 1'b0, 1'b0);
   endtask

   // One miss transaction: optional writeback of the victim, then a fill, then
   // the retried request hits in the freshly filled way.
   task automatic run_miss(input string name, input logic rd, input logic wr,
                           input logic l, input logic v, input logic d,
                           input int wb_delay, input int fill_delay,
                           input logic toggle_lru);
      outs_t exp;
      logic  victim;
      logic  cur_lru;
      victim  = l;
      cur_lru = l;
      @(negedge clk);
      applyStimulus(rd, wr, 1'b0, 1'b0, l, v, d, 1'b0);
      #1;
      exp = '0;
      exp.victim_way = l;
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s miss detect: got %h expected %h", name, obs, exp);
      end
      exp_misses = sat_inc(exp_misses);
      if (v && d) begin
         for (int i = 0; i <= wb_delay; i++) begin
            @(negedge clk);
            if (toggle_lru) cur_lru = ~cur_lru;
            lru       = cur_lru;
            pmem_resp = (i == wb_delay);
            #1;
            exp = '0;
            exp.pmem_write       = 1'b1;
            exp.pmem_address_sel = 1'b1;
            exp.victim_way       = victim;
            checks++;
            if (obs !== exp) begin
               errors++;
               $display("[TB] FAIL %s writeback cycle %0d: got %h expected %h",
                        name, i, obs, exp);
            end
         end
      end
      for (int i = 0; i <= fill_delay; i++) begin
         @(negedge clk);
         if (toggle_lru) cur_lru = ~cur_lru;
         lru       = cur_lru;
         pmem_resp = (i == fill_delay);
         #1;
         exp = '0;
         exp.pmem_read  = 1'b1;
         exp.victim_way = victim;
         if (i == fill_delay) begin
            exp.load_data   = onehot(victim);
            exp.data_sel    = 1'b1;
            exp.load_tag    = onehot(victim);
            exp.clear_dirty = onehot(victim);
         end
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s fill cycle %0d: got %h expected %h",
                     name, i, obs, exp);
         end
      end
      // The filled way now matches the tag, so the retried request hits.
      @(negedge clk);
      pmem_resp = 1'b0;
      hit0      = (victim == 1'b0);
      hit1      = (victim == 1'b1);
      #1;
      exp = '0;
      exp.mem_resp   = 1'b1;
      exp.victim_way = cur_lru;
      exp.load_lru   = 1'b1;
      exp.lru_in     = ~victim;
      if (wr) begin
         exp.load_data = onehot(victim);
         exp.set_dirty = onehot(victim);
      end
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s retry hit: got %h expected %h", name, obs, exp);
      end
      exp_hits = sat_inc(exp_hits);
      @(posedge clk);
      #1;
      checks++;
      if ({hit_count, miss_count} !== {CNT_WIDTH'(exp_hits), CNT_WIDTH'(exp_misses)}) begin
         errors++;
         $display("[TB] FAIL %s counters: got %0d/%0d expected %0d/%0d",
                  name, hit_count, miss_count, exp_hits, exp_misses);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, cur_lru, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs !== outs_t'(0) || hit_count !== '0 || miss_count !== '0) begin
         errors++;
         $display("[TB] FAIL reset state: got %h/%0d/%0d expected 0/0/0",
                  obs, hit_count, miss_count);
      end
      reset = 1'b0;
      exp_hits   = 0;
      exp_misses = 0;
      #1;
      checks++;
      if (obs !== outs_t'(0)) begin
         errors++;
         $display("[TB] FAIL idle after reset: got %h expected 0", obs);
      end
   endtask

   task automatic test_read_hit();
      run_hit("read_hit_way1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic test_write_hit();
      run_hit("write_hit_way0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      run_hit("write_hit_both", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
   endtask

   task automatic test_clean_miss();
      run_miss("read_miss_clean", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 4, 1'b0);
   endtask

   task automatic test_dirty_miss();
      run_miss("write_miss_dirty", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3, 2, 1'b1);
      run_miss("wb_immediate", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b1);
   endtask

   task automatic test_random();
      logic h0;
      logic h1;
      logic rd;
      logic wr;
      for (int n = 0; n < 40; n++) begin
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         if (!rd && !wr) rd = 1'b1;
         if ($urandom_range(0, 1) == 0) begin
            h0 = 1'($urandom_range(0, 1));
            h1 = h0 ? 1'($urandom_range(0, 1)) : 1'b1;
            run_hit("random_hit", rd, wr, h0, h1, 1'($urandom_range(0, 1)));
         end else begin
            run_miss("random_miss", rd, wr, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)));
         end
      end
   endtask

   // Reset two cycles into a writeback, followed by a stray pmem_resp.
   task automatic test_reset_mid_writeback();
      outs_t exp;
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      exp = '0;
      exp.pmem_write       = 1'b1;
      exp.pmem_address_sel = 1'b1;
      exp.victim_way       = 1'b1;
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL mid_wb entry: got %h expected %h", obs, exp);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (obs !== outs_t'(0)) begin
         errors++;
         $display("[TB] FAIL mid_wb under reset: got %h expected 0", obs);
      end
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      exp_hits   = 0;
      exp_misses = 0;
      #1;
      checks++;
      if (obs !== outs_t'(0) || hit_count !== '0 || miss_count !== '0) begin
         errors++;
         $display("[TB] FAIL mid_wb after reset: got %h/%0d/%0d expected 0/0/0",
                  obs, hit_count, miss_count);
      end
      @(negedge clk);
      pmem_resp = 1'b0;
      #1;
      checks++;
      if (obs !== outs_t'(0)) begin
         errors++;
         $display("[TB] FAIL stray pmem_resp: got %h expected 0", obs);
      end
   endtask

   // Drive enough back-to-back hits to saturate the hit counter, then more.
   task automatic test_hit_saturation();
      int remaining;
      remaining = CNT_MAX - exp_hits;
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (remaining) @(posedge clk);
      exp_hits = CNT_MAX;
      #1;
      checks++;
      if (hit_count !== CNT_WIDTH'(exp_hits)) begin
         errors++;
         $display("[TB] FAIL hit_count reach max: got %h expected %h",
                  hit_count, CNT_WIDTH'(exp_hits));
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (hit_count !== CNT_WIDTH'(exp_hits) || mem_resp !== 1'b1) begin
         errors++;
         $display("[TB] FAIL hit_count saturate: got %h/%b expected %h/1",
                  hit_count, mem_resp, CNT_WIDTH'(exp_hits));
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      exp_hits   = 0;
      exp_misses = 0;
      reset      = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_read_hit();
      test_write_hit();
      test_clean_miss();
      test_dirty_miss();
      test_random();
      test_reset_mid_writeback();
      test_read_hit();
      test_clean_miss();
      test_hit_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cache_line_controller.md
Name: cache_line_controller

Overview:
- Sequencing FSM for the two-way set-associative LC-3b cache.
- Detects hit/miss, updates LRU, and orders dirty-victim writeback before line allocation.
- Drives the physical-address mux select and victim-way select consumed by the line address generator, and the physical memory read/write handshake.
- Sits between the CPU memory port and physical memory, beside the cache datapath arrays.

Parameters:
- CNT_WIDTH, 16, width of the saturating hit and miss performance counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- mem_read  input  1  CPU read request; held until mem_resp
- mem_write  input  1  CPU write request; held until mem_resp
- hit0  input  1  way0 valid and tag match for current set
- hit1  input  1  way1 valid and tag match for current set
- lru  input  1  LRU bit of current set (0 = way0 is victim)
- valid_victim  input  1  valid bit of the way selected by victim_way
- dirty_victim  input  1  dirty bit of the way selected by victim_way
- pmem_resp  input  1  physical memory transfer done; one-cycle pulse
- mem_resp  output  1  CPU request complete
- pmem_read  output  1  physical line read request
- pmem_write  output  1  physical line write request
- pmem_address_sel  output  1  0 = CPU address, 1 = {victim tag, set, 5'b0}
- victim_way  output  1  way selected for writeback/allocate; also selects tag for address generator
- load_data  output  2  per-way data array write enable
- data_sel  output  1  0 = CPU write merge, 1 = full line from pmem
- load_tag  output  2  per-way tag/valid write enable
- set_dirty  output  2  per-way dirty set; clear_dirty  output  2  per-way dirty clear
- load_lru  output  1  write LRU bit; lru_in  output  1  new LRU value
- hit_count  output  CNT_WIDTH  saturating count of hit responses
- miss_count  output  CNT_WIDTH  saturating count of miss entries

Behaviour:
- States: IDLE, WRITEBACK, ALLOCATE. Reset -> IDLE; every output 0; victim register 0; counters 0.
- Request = mem_read | mem_write. If both are asserted, it is treated as a write.
- IDLE, no request: all strobes 0, stay.
- IDLE, request, hit0|hit1: mem_resp=1 combinationally, same cycle (0-cycle hit latency).
  - Hit way = way0 if hit0, else way1. Way0 wins if both hit.
  - load_lru=1, lru_in = ~hitway.
  - On write: load_data[hitway]=1, data_sel=0, set_dirty[hitway]=1.
  - hit_count += 1. Stay in IDLE.
- IDLE, request, miss: latch victim_way <= lru; miss_count += 1.
  - Next state WRITEBACK if valid_victim & dirty_victim, else ALLOCATE.
  - mem_resp=0.
- WRITEBACK: pmem_write=1, pmem_address_sel=1, victim_way = latched value.
  - Hold until pmem_resp=1, then ALLOCATE.
- ALLOCATE: pmem_read=1, pmem_address_sel=0.
  - On pmem_resp=1, in the same cycle: load_data[victim]=1, data_sel=1, load_tag[victim]=1, clear_dirty[victim]=1.
  - Next state IDLE. The request is re-evaluated there and hits; total miss latency = clean fill + 1 cycle.
- pmem_read and pmem_write are never both 1. Both are held constant between entry and pmem_resp.
- Counters saturate at all-ones. No wrap.
- The request dropping mid-miss is illegal (no protection required). The FSM still completes the fill.
- Reset mid-WRITEBACK/ALLOCATE: next cycle IDLE, pmem strobes 0, no array writes. A late pmem_resp in IDLE is ignored.
- victim_way is stable from miss detection until return to IDLE, even if lru changes.

Test Plan:
- Read, hit1=1, lru=1 -> same-cycle mem_resp=1, load_lru=1, lru_in=0, hit_count 0->1, no pmem activity.
- Write, hit0=1 -> mem_resp=1, load_data=2'b01, data_sel=0, set_dirty=2'b01, lru_in=1.
- Read miss, lru=0, valid=1, dirty=0 -> ALLOCATE next cycle, pmem_read=1, sel=0.
  - pmem_resp after 5 cycles -> load_data=2'b01, load_tag=2'b01, clear_dirty=2'b01.
  - Then hit next cycle; miss_count=1.
- Write miss, lru=1, valid=1, dirty=1 -> WRITEBACK, pmem_write=1, sel=1, victim_way=1.
  - pmem_resp -> ALLOCATE, pmem_read=1.
  - Toggling lru during the miss leaves victim_way=1.
- reset asserted 2 cycles into WRITEBACK -> IDLE next cycle, all outputs 0, counters 0; stray pmem_resp ignored.
- Force hit_count to 16'hFFFF, issue a hit -> stays 16'hFFFF.
